// File: rtl/alu_cmd_sequencer.sv
// alu_cmd_sequencer: fetches operands from an 8 x 32-bit register file, drives
// an external combinational ALU and writes the result back, one command every
// three cycles (IDLE -> EXEC -> WB).
// Optional feature: define ATOMIC_CAS_EN to turn opcode 111 into a
// compare-and-swap (R[a1] == R[a3] ? R[a1] <= R[a2]) with status in R7.
// Without it, opcode 111 is passed to the ALU like any other opcode.
module alu_cmd_sequencer (
    input  logic        clk,
    input  logic        rst,
    input  logic        cmd_valid,
    output logic        cmd_ready,
    input  logic [11:0] command,
    output logic [2:0]  alu_op_code,
    output logic [31:0] data_a,
    output logic [31:0] data_b,
    input  logic [31:0] y,
    input  logic        O,
    input  logic        C,
    input  logic        Z,
    input  logic        N,
    output logic        done,
    output logic [3:0]  flags,
    output logic        cas_success,
    input  logic [2:0]  rd_addr,
    output logic [31:0] rd_data
);

    localparam int unsigned DATA_W  = 32;
    localparam int unsigned ADDR_W  = 3;
    localparam int unsigned OP_W    = 3;
    localparam int unsigned FLAG_W  = 4;
    localparam int unsigned NREG    = 8;

    localparam logic [OP_W-1:0]   OP_SUB     = 3'b001;
    localparam logic [ADDR_W-1:0] STATUS_REG = 3'd7;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_WB   = 2'd2
    } state_t;

    state_t                 state_q, state_d;
    logic                   ready_q, ready_d;
    logic [ADDR_W-1:0]      dst_q, dst_d;
    logic [DATA_W-1:0]      regs_q [NREG];
    logic [DATA_W-1:0]      regs_d [NREG];
    logic [OP_W-1:0]        op_q, op_d;
    logic [DATA_W-1:0]      a_q, a_d;
    logic [DATA_W-1:0]      b_q, b_d;
    logic                   done_q, done_d;
    logic [FLAG_W-1:0]      flags_q, flags_d;

    logic [OP_W-1:0]        new_opc;
    logic [ADDR_W-1:0]      new_a1, new_a2, new_a3;

    assign new_opc = command[11:9];
    assign new_a1  = command[8:6];
    assign new_a2  = command[5:3];
    assign new_a3  = command[2:0];

`ifdef ATOMIC_CAS_EN
    logic                   cas_op_q, cas_op_d;
    logic [ADDR_W-1:0]      src1_q, src1_d;
    logic [ADDR_W-1:0]      src2_q, src2_d;
    logic                   cas_q, cas_d;
    logic                   new_cas;

    assign new_cas = (new_opc == 3'b111);
`endif

    // Next-state, operand launch and writeback decode
    always_comb begin
        state_d = state_q;
        dst_d   = dst_q;
        regs_d  = regs_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        done_d  = 1'b0;
        flags_d = flags_q;
`ifdef ATOMIC_CAS_EN
        cas_op_d = cas_op_q;
        src1_d   = src1_q;
        src2_d   = src2_q;
        cas_d    = cas_q;
`endif

        case (state_q)
            S_IDLE: begin
                if (cmd_valid) begin
                    dst_d   = new_a3;
                    a_d     = regs_q[new_a1];
                    op_d    = new_opc;
                    b_d     = regs_q[new_a2];
`ifdef ATOMIC_CAS_EN
                    cas_op_d = new_cas;
                    src1_d   = new_a1;
                    src2_d   = new_a2;
                    if (new_cas) begin
                        op_d = OP_SUB;
                        b_d  = regs_q[new_a3];
                    end
`endif
                    state_d = S_EXEC;
                end
            end
            S_EXEC: begin
                state_d = S_WB;
                done_d  = 1'b1;
                flags_d = {O, C, Z, N};
`ifdef ATOMIC_CAS_EN
                cas_d = 1'b0;
                if (cas_op_q) begin
                    if (Z) begin
                        regs_d[src1_q] = regs_q[src2_q];
                    end
                    // Status write comes last so it wins when a1 is R7
                    regs_d[STATUS_REG] = DATA_W'(Z);
                    cas_d = Z;
                end else begin
                    regs_d[dst_q] = y;
                end
`else
                regs_d[dst_q] = y;
`endif
            end
            S_WB: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        ready_d = (state_d == S_IDLE);
    end

    // State and datapath registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            ready_q <= 1'b1;
            dst_q   <= '0;
            regs_q  <= '{default: '0};
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            done_q  <= 1'b0;
            flags_q <= '0;
`ifdef ATOMIC_CAS_EN
            cas_op_q <= 1'b0;
            src1_q   <= '0;
            src2_q   <= '0;
            cas_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            ready_q <= ready_d;
            dst_q   <= dst_d;
            regs_q  <= regs_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            done_q  <= done_d;
            flags_q <= flags_d;
`ifdef ATOMIC_CAS_EN
            cas_op_q <= cas_op_d;
            src1_q   <= src1_d;
            src2_q   <= src2_d;
            cas_q    <= cas_d;
`endif
        end
    end

    assign cmd_ready   = ready_q;
    assign alu_op_code = op_q;
    assign data_a      = a_q;
    assign data_b      = b_q;
    assign done        = done_q;
    assign flags       = flags_q;
    assign rd_data     = regs_q[rd_addr];
`ifdef ATOMIC_CAS_EN
    assign cas_success = cas_q;
`else
    assign cas_success = 1'b0;
`endif

endmodule

// File: doc/alu_cmd_sequencer.md
ALU_CMD_SEQUENCER -- requirements
Module: alu_cmd_sequencer

Interface
REQ-001 SHALL have ports: clk  in  1  rising-edge clock.
REQ-002 SHALL have: rst  in  1  reset, asynchronous, active-high.
REQ-003 SHALL have: cmd_valid  in  1  command offered; cmd_ready  out  1  sequencer can accept.
REQ-004 SHALL have: command  in  12  [11:9] opcode, [8:6] a1, [5:3] a2, [2:0] a3.
REQ-005 SHALL have: alu_op_code  out  3; data_a  out  32; data_b  out  32  registered drive to the external ALU.
REQ-006 SHALL have: y  in  32 ALU result; O, C, Z, N  in  1 each ALU flags, combinational from ALU inputs.
REQ-007 SHALL have: done  out  1  one-cycle completion pulse; flags  out  4  latched {O,C,Z,N}; cas_success  out  1.
REQ-008 SHALL have: rd_addr  in  3; rd_data  out  32  combinational debug read of R[rd_addr].

Function
REQ-009 SHALL own 8 x 32-bit registers R0..R7, all writable.
REQ-010 SHALL use FSM states IDLE, EXEC, WB; cmd_ready = 1 only in IDLE.
REQ-011 SHALL accept a command on a rising edge with cmd_valid & cmd_ready; same edge: capture command, load alu_op_code, data_a, data_b, go to EXEC.
REQ-012 Ordinary op (opcode 000-110) SHALL load alu_op_code = opcode, data_a = R[a1], data_b = R[a2].
REQ-013 Ordinary op SHALL, on EXEC->WB edge, write R[a3] <= y and flags <= {O,C,Z,N}.
REQ-014 CAS (opcode 111) SHALL load alu_op_code = 001 (subtract), data_a = R[a1], data_b = R[a3].
REQ-015 CAS SHALL, on EXEC->WB edge: if Z, R[a1] <= R[a2] and R7 <= 1; else R7 <= 0; flags updated; cas_success <= Z.
REQ-016 CAS with a1 = 7 SHALL resolve the R7 write conflict in favour of the status value (0/1).
REQ-017 done SHALL be 1 for exactly the WB cycle; WB -> IDLE unconditionally; fixed latency = accept edge + 2 edges to done.
REQ-018 Writeback SHALL be visible on rd_data during the WB cycle.
REQ-019 cmd_valid/command during EXEC or WB SHALL be ignored; no queueing.
REQ-020 cas_success SHALL hold until the next WB; ordinary ops clear it to 0.
REQ-021 data_a, data_b, alu_op_code SHALL hold their values from accept until the next accept.
REQ-022 Back-to-back commands SHALL achieve one command per 3 cycles with cmd_valid held high.

Reset
REQ-023 rst high SHALL immediately: FSM -> IDLE, R0..R7 = 0, alu_op_code = 0, data_a = data_b = 0, flags = 0, done = 0, cas_success = 0.
REQ-024 rst during EXEC or WB SHALL discard the in-flight command with no writeback and no done pulse.
REQ-025 cmd_ready SHALL be 1 in the first cycle after rst deasserts.

Configuration
REQ-026 Macro ATOMIC_CAS_EN defined: opcode 111 SHALL behave per REQ-014..REQ-016.
REQ-027 ATOMIC_CAS_EN undefined: opcode 111 SHALL be an ordinary op (REQ-012/013, alu_op_code = 111) and cas_success SHALL be tied 0.

Verification (external ALU model: 000 add, 001 sub)
REQ-028 Reset, then poll rd_addr 0..7 -> all rd_data = 0; cmd_ready = 1; done = 0.
REQ-029 R1=5, R2=7 (seeded via adds), add command 000_001_010_011 -> data_a=5, data_b=7 in EXEC; done at +2 edges; R3=12; flags Z=0.
REQ-030 ATOMIC_CAS_EN, R1=10, R2=99, R3=10, command 111_001_010_011 -> alu_op_code=001; R1=99, R7=1, cas_success=1; then R3=11 repeat -> R1 unchanged 99, R7=0, cas_success=0.
REQ-031 cmd_valid held high with two commands -> second accepted exactly 3 cycles after first; command changed during EXEC ignored.
REQ-032 Assert rst in EXEC of an add to R3 -> no done pulse, R3=0, cmd_ready=1 after release.
REQ-033 Without ATOMIC_CAS_EN, opcode 111 -> alu_op_code=111, R[a3]=y, cas_success=0.
